pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Sequencer that feeds the external 3-bit Mealy pattern detector ("010"/"101"). It accepts a parallel word over a valid/ready handshake and flushes the detector's history. It then shifts the word into the detector MSB-first, one bit per cycle, and accumulates the detector's match flags. Finally it returns both match counts through an output handshake. It sits between a word producer and the detector and is the only driver of the detector's input.

Parameters:
WIDTH, 10, bits per input word; must be >= 3.
CNT_W, 4, width of each match counter; counters saturate at 2^CNT_W-1.

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a word on in_word
in_word  in  WIDTH  word to scan, bit WIDTH-1 scanned first
in_ready  out  1  controller can accept a word
det_flush  out  1  one-cycle pulse: detector clears its 3-bit history
det_valid  out  1  det_bit is a valid stream bit this cycle
det_bit  out  1  stream bit to detector
det_match  in  2  detector result, registered; [1] = "010" seen, [0] = "101" seen; valid one cycle after the det_valid bit that completed the window
out_valid  out  1  counts valid
out_ready  in  1  consumer takes counts
cnt_010  out  CNT_W  number of "010" windows in the last word
cnt_101  out  CNT_W  number of "101" windows in the last word

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in IDLE. det_flush=0, det_valid=0, det_bit=0, out_valid=0, cnt_010=0, cnt_101=0. FSM=IDLE. Bit index=0.
- FSM states: IDLE, FLUSH, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, latch in_word, set idx=WIDTH-1, clear both counters, and go to FLUSH. in_word is ignored in all other states.
- FLUSH (1 cycle): det_flush=1, in_ready=0, then go to SHIFT.
- SHIFT (WIDTH cycles): det_valid=1, det_bit=word[idx], idx decrements each cycle. When idx==0, go to DRAIN.
- DRAIN (1 cycle): det_valid=0. This cycle exists only to sample the det_match produced by the final bit. Then go to DONE.
- Counting uses a registered copy of det_valid (v_d). In every cycle with v_d=1:
  - cnt_010 += det_match[1]
  - cnt_101 += det_match[0]
  - each counter saturates independently.
- det_match is ignored whenever v_d=0, including the first two stream bits, whose windows are incomplete by construction in the detector.
- DONE: out_valid=1, and counts hold stable. When out_valid&&out_ready, go to IDLE. Counts keep their values until the next accept.
- Latency: accept in cycle T, FLUSH at T+1, SHIFT at T+2..T+WIDTH+1, DRAIN at T+WIDTH+2, out_valid first high at T+WIDTH+3. The earliest next accept is the cycle after the out handshake. There is no overlap between words.
- Simultaneous events: in_valid during FLUSH/SHIFT/DRAIN/DONE is not accepted (in_ready=0). out_ready while not in DONE has no effect.
- Reset mid-operation: an immediate return to the reset values. The partially scanned word is discarded, and no out_valid is produced for it. The next word is preceded by FLUSH as usual.
- det_bit holds 0 whenever det_valid=0.

Test Plan:
1. WIDTH=10, in_word=0110101011, out_ready=1 -> det_bit sequence 0,1,1,0,1,0,1,0,1,1 over 10 consecutive det_valid cycles; cnt_010=2, cnt_101=3; out_valid at accept+13.
2. in_word=1010101010 -> cnt_010=4, cnt_101=4. in_word=0000000000 -> both 0. Back-to-back words with in_valid held high -> second accept occurs exactly one cycle after the first out handshake, with counts cleared before rescan.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and counts stable, in_ready=0, det_valid=0; release -> IDLE next cycle.
4. Assert reset for 1 cycle during SHIFT (after 4 bits) -> next cycle all outputs at reset values, no out_valid; next word 0110101011 still yields 2/3 with det_flush pulsed first.
5. CNT_W=2, WIDTH=10, in_word=1010101010 -> both counters saturate at 3.
6. in_valid pulsed during SHIFT with a different word -> ignored; the result corresponds to the originally latched word.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Sequencer for the external 3-bit "010"/"101" detector: accepts a word, flushes the
// detector, shifts the word in MSB-first and returns saturating match counts.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for a word
// FLUSH | one-cycle det_flush pulse to clear detector history
// SHIFT | one word bit per cycle to the detector, MSB first
// DRAIN | no new bit; lets the registered match of the last bit land
// DONE  | out_valid high, counts held until consumer takes them
module pattern_scan_ctrl #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    output logic             det_flush,
    output logic             det_valid,
    output logic             det_bit,
    input  logic [1:0]       det_match,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_010,
    output logic [CNT_W-1:0] cnt_101
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vdly_q;
    logic [CNT_W-1:0]   c010_q, c010_d, c101_q, c101_d;
    logic               accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && (c != {CNT_W{1'b1}}))
            return c + 1'b1;
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            vdly_q  <= 1'b0;
            c010_q  <= '0;
            c101_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            vdly_q  <= det_valid;
            c010_q  <= c010_d;
            c101_q  <= c101_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        c010_d    = c010_q;
        c101_d    = c101_q;
        in_ready  = 1'b0;
        det_flush = 1'b0;
        det_valid = 1'b0;
        det_bit   = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        // Matches arrive one cycle after their bit, so gate on the delayed valid.
        if (vdly_q) begin
            c010_d = sat_inc(c010_q, det_match[1]);
            c101_d = sat_inc(c101_q, det_match[0]);
        end

        unique case (state_q)
            IDLE: begin
                in_ready = !reset;
                accept   = in_valid && !reset;
                if (accept) begin
                    word_d  = in_word;
                    idx_d   = IDX_W'(WIDTH - 1);
                    c010_d  = '0;
                    c101_d  = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                det_flush = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                det_valid = 1'b1;
                det_bit   = word_q[idx_q];
                if (idx_q == '0)
                    state_d = DRAIN;
                else
                    idx_d = idx_q - 1'b1;
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_010 = c010_q;
    assign cnt_101 = c101_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl with a behavioural detector model; a second
// instance with 2-bit counters runs in lockstep to exercise saturation.
module tb_pattern_scan_ctrl;
    localparam int W = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_word;
    logic          out_ready;
    logic [1:0]    det_match;
    logic          in_ready, det_flush, det_valid, det_bit, out_valid;
    logic [3:0]    cnt_010, cnt_101;
    logic          s_in_ready, s_det_flush, s_det_valid, s_det_bit, s_out_valid;
    logic [1:0]    s_cnt_010, s_cnt_101;

    pattern_scan_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .det_flush(det_flush), .det_valid(det_valid),
        .det_bit(det_bit), .det_match(det_match), .out_valid(out_valid),
        .out_ready(out_ready), .cnt_010(cnt_010), .cnt_101(cnt_101));

    pattern_scan_ctrl #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(s_in_ready), .det_flush(s_det_flush), .det_valid(s_det_valid),
        .det_bit(s_det_bit), .det_match(det_match), .out_valid(s_out_valid),
        .out_ready(out_ready), .cnt_010(s_cnt_010), .cnt_101(s_cnt_101));

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] word;
        int           c010;
        int           c101;
        int           t_acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_hs = -100;
    int   acc_cyc;
    int   bit_pos;
    int   nbits;
    bit   ov_seen;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Behavioural detector: registered match, only for complete 3-bit windows.
    logic [2:0] hist;
    int         hn;
    always @(posedge clock) begin : det_model
        logic [2:0] win;
        if (reset || det_flush) begin
            hist      <= '0;
            hn        <= 0;
            det_match <= '0;
        end else if (det_valid) begin
            win       = {hist[1:0], det_bit};
            hist      <= win;
            hn        <= hn + 1;
            det_match <= (hn >= 2) ? {win == 3'b010, win == 3'b101} : 2'b00;
        end else begin
            det_match <= '0;
        end
    end

    always @(negedge clock) begin : monitor
        int s010, s101;
        if (reset) begin
            ov_seen = 0;
            bit_pos = W - 1;
            nbits   = 0;
        end else begin
            check("lockstep_valid", s_out_valid == out_valid && s_det_bit == det_bit, s_out_valid, out_valid);
            if (!det_valid)
                check("det_bit_idle", det_bit == 1'b0, det_bit, 0);
            if (det_flush) begin
                check("flush_has_exp", sb.size() > 0, sb.size(), 1);
                if (sb.size() > 0)
                    check("flush_latency", cyc == sb[0].t_acc + 1, cyc, sb[0].t_acc + 1);
                check("cnt_clear_010", cnt_010 == 0, cnt_010, 0);
                check("cnt_clear_101", cnt_101 == 0, cnt_101, 0);
                bit_pos = W - 1;
                nbits   = 0;
            end
            if (det_valid) begin
                if (sb.size() > 0 && bit_pos >= 0)
                    check("det_bit", det_bit == sb[0].word[bit_pos], det_bit, sb[0].word[bit_pos]);
                bit_pos--;
                nbits++;
            end
            if (out_valid && !ov_seen) begin
                ov_seen = 1;
                check("out_has_exp", sb.size() > 0, sb.size(), 1);
                if (sb.size() > 0)
                    check("out_latency", cyc == sb[0].t_acc + W + 3, cyc, sb[0].t_acc + W + 3);
                check("bits_shifted", nbits == W, nbits, W);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                s010 = (sb[0].c010 > 3) ? 3 : sb[0].c010;
                s101 = (sb[0].c101 > 3) ? 3 : sb[0].c101;
                check("cnt_010", cnt_010 == sb[0].c010, cnt_010, sb[0].c010);
                check("cnt_101", cnt_101 == sb[0].c101, cnt_101, sb[0].c101);
                check("sat_cnt_010", s_cnt_010 == s010, s_cnt_010, s010);
                check("sat_cnt_101", s_cnt_101 == s101, s_cnt_101, s101);
                void'(sb.pop_front());
                last_hs = cyc;
                ov_seen = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input int e010, input int e101, input bit keep);
        int   n;
        exp_t e;
        in_word  = w;
        in_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1'b0, n, 200);
        end else begin
            e.word  = w;
            e.c010  = e010;
            e.c101  = e101;
            e.t_acc = cyc;
            sb.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clock);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", sb.size() == 0, n, 300);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        @(negedge clock);
        check("rst_in_ready", in_ready == 1'b0, in_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready_idle", in_ready == 1'b1, in_ready, 1);
        check("rst_outs", {det_flush, det_valid, det_bit, out_valid} == 4'b0, {det_flush, det_valid, det_bit, out_valid}, 0);
        check("rst_cnts", cnt_010 == 0 && cnt_101 == 0, {cnt_010, cnt_101}, 0);
        @(posedge clock);
        #1;

        // Directed vectors with hand-counted windows.
        send(10'b0110101011, 2, 3, 0); wait_idle();
        send(10'b1010101010, 4, 4, 0); wait_idle();
        send(10'b0000000000, 0, 0, 0); wait_idle();
        send(10'b0101101101, 1, 3, 0); wait_idle();
        send(10'b0010100100, 3, 1, 0); wait_idle();
        send(10'b1111111111, 0, 0, 0); wait_idle();

        // Back-to-back with in_valid held high.
        send(10'b1010101010, 4, 4, 1);
        send(10'b0000000000, 0, 0, 0);
        check("b2b_accept", acc_cyc == last_hs + 1, acc_cyc, last_hs + 1);
        wait_idle();

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(10'b0110101011, 2, 3, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("bp_out_valid_seen", out_valid == 1'b1, out_valid, 1);
        repeat (5) begin
            @(negedge clock);
            check("bp_out_valid", out_valid == 1'b1, out_valid, 1);
            check("bp_hold_010", cnt_010 == 2, cnt_010, 2);
            check("bp_hold_101", cnt_101 == 3, cnt_101, 3);
            check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
            check("bp_det_valid", det_valid == 1'b0, det_valid, 0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_idle_in_ready", in_ready == 1'b1, in_ready, 1);
        check("bp_idle_out_valid", out_valid == 1'b0, out_valid, 0);
        check("bp_keep_010", cnt_010 == 2, cnt_010, 2);
        @(posedge clock);
        #1;

        // Reset after four shifted bits.
        send(10'b1010101010, 4, 4, 0);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", in_ready == 1'b0, in_ready, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clock);
        check("midrst_outs", {det_flush, det_valid, det_bit, out_valid} == 4'b0, {det_flush, det_valid, det_bit, out_valid}, 0);
        check("midrst_cnts", cnt_010 == 0 && cnt_101 == 0, {cnt_010, cnt_101}, 0);
        check("midrst_in_ready_idle", in_ready == 1'b1, in_ready, 1);
        repeat (15) begin
            @(negedge clock);
            check("midrst_no_out", out_valid == 1'b0, out_valid, 0);
        end
        @(posedge clock);
        #1;
        send(10'b0110101011, 2, 3, 0); wait_idle();

        // New word offered mid-scan must be ignored.
        send(10'b0110101011, 2, 3, 0);
        repeat (3) @(posedge clock);
        #1;
        in_word  = 10'b1010101010;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
